// File: rtl/adder_arbiter.sv
// Round-robin sharing of one registered adder among NUM_REQ valid/ready requesters; tags route each sum back to its owner.
// Define ADDER_ARBITER_STATS_EN to add saturating grant/stall counters (o_grant_cnt, o_stall_cnt).
module adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int ADD_LAT = 1
) (
   input  logic                         clk,
   input  logic                         i_rst,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   output logic [NUM_REQ-1:0]           o_req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]     i_req_a,
   input  logic [NUM_REQ*WIDTH-1:0]     i_req_b,
   output logic [NUM_REQ-1:0]           o_rsp_valid,
   input  logic [NUM_REQ-1:0]           i_rsp_ready,
   output logic [NUM_REQ*(WIDTH+1)-1:0] o_rsp_sum,
   output logic [WIDTH-1:0]             o_add_a,
   output logic [WIDTH-1:0]             o_add_b,
   input  logic [WIDTH:0]               i_add_sum
`ifdef ADDER_ARBITER_STATS_EN
   ,
   output logic [31:0]                  o_grant_cnt,
   output logic [31:0]                  o_stall_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INFLIGHT,
      ST_DONE
   } state_e;

   state_e             state_q [NUM_REQ];
   state_e             state_d [NUM_REQ];
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]   add_a_q, add_a_d;
   logic [WIDTH-1:0]   add_b_q, add_b_d;
   logic [ADD_LAT:0]   tag_vld_q;
   logic [IDX_W-1:0]   tag_idx_q [ADD_LAT+1];
   logic [WIDTH:0]     sum_q [NUM_REQ];

   logic [WIDTH-1:0]   req_a [NUM_REQ];
   logic [WIDTH-1:0]   req_b [NUM_REQ];
   logic [NUM_REQ-1:0] eligible;
   logic               grant_vld;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   cand;
   logic               ret_vld;
   logic [IDX_W-1:0]   ret_idx;

   always_comb begin
      o_rsp_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         req_a[k]       = i_req_a[k*WIDTH +: WIDTH];
         req_b[k]       = i_req_b[k*WIDTH +: WIDTH];
         eligible[k]    = !i_rst && i_req_valid[k] && (state_q[k] == ST_IDLE);
         o_rsp_valid[k] = (state_q[k] == ST_DONE);
         o_rsp_sum[k*(WIDTH+1) +: WIDTH+1] = sum_q[k];
      end
   end

   // Round-robin scan starting at ptr_q; the first eligible requester wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld && eligible[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
         cand = (cand == IDX_W'(NUM_REQ-1)) ? '0 : cand + IDX_W'(1);
      end
   end

   always_comb begin
      o_req_ready = '0;
      if (grant_vld) o_req_ready[grant_idx] = 1'b1;
      ptr_d   = ptr_q;
      add_a_d = '0;
      add_b_d = '0;
      if (grant_vld) begin
         ptr_d   = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
         add_a_d = req_a[grant_idx];
         add_b_d = req_b[grant_idx];
      end
   end

   // Tag entry 0 travels with o_add_a/o_add_b; entry ADD_LAT lines up with a valid i_add_sum.
   assign ret_vld = tag_vld_q[ADD_LAT];
   assign ret_idx = tag_idx_q[ADD_LAT];

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         state_d[k] = state_q[k];
         case (state_q[k])
            ST_IDLE:     if (grant_vld && grant_idx == IDX_W'(k)) state_d[k] = ST_INFLIGHT;
            ST_INFLIGHT: if (ret_vld && ret_idx == IDX_W'(k))     state_d[k] = ST_DONE;
            ST_DONE:     if (i_rsp_ready[k])                      state_d[k] = ST_IDLE;
            default:                                              state_d[k] = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            state_q[k] <= ST_IDLE;
            sum_q[k]   <= '0;
         end
         for (int s = 0; s <= ADD_LAT; s++) tag_idx_q[s] <= '0;
         tag_vld_q <= '0;
         ptr_q     <= '0;
         add_a_q   <= '0;
         add_b_q   <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) state_q[k] <= state_d[k];
         tag_vld_q[0] <= grant_vld;
         tag_idx_q[0] <= grant_idx;
         for (int s = 1; s <= ADD_LAT; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_idx_q[s] <= tag_idx_q[s-1];
         end
         if (ret_vld) sum_q[ret_idx] <= i_add_sum;
         ptr_q   <= ptr_d;
         add_a_q <= add_a_d;
         add_b_q <= add_b_d;
      end
   end

   assign o_add_a = add_a_q;
   assign o_add_b = add_b_q;

   // A returning tag must belong to a requester that is still waiting for it.
   a_tag_owner_inflight : assert property (@(posedge clk) disable iff (i_rst)
      !(ret_vld && state_q[ret_idx] != ST_INFLIGHT));

`ifdef ADDER_ARBITER_STATS_EN
   logic [31:0] grant_cnt_q, grant_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (grant_vld && grant_cnt_q != '1) grant_cnt_d = grant_cnt_q + 32'd1;
      if ((|i_req_valid) && !grant_vld && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_grant_cnt = grant_cnt_q;
   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
